// File: rtl/rename_queue.sv
// ---------------------------------------------------------------------------
// rename_queue
//   Decode-to-rename instruction FIFO. Decode (ID) enqueues decoded
//   instructions; Rename sees the oldest entry on the show-ahead head outputs
//   and removes it with RNM_DQ. FLUSH throws away every entry so the front end
//   can restart after a mispredict or exception.
//
//   Optional feature macro: RNMQ_AFULL_EN
//     defined   -> AFULL_LVL parameter and registered RNMQ_afull output exist.
//     undefined -> neither the parameter nor the port/logic is present.
//
// Ports
//   CLK, RESET           rising-edge clock, synchronous active-high reset
//   FLUSH                discard all entries (beats push/pop this cycle)
//   ID_NQ + *_IN         enqueue request and the 135-bit entry payload
//   RNM_DQ               dequeue request from Rename (ignored while empty)
//   *_OUT                head entry fields, forced to zero while empty
//   RNMQ_empty/full      registered occupancy flags
//   RNMQ_count           registered occupancy, 0..DEPTH
//   RNMQ_afull           registered, count >= AFULL_LVL (macro only)
// ---------------------------------------------------------------------------
module rename_queue #(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3
`ifdef RNMQ_AFULL_EN
  ,
  parameter int AFULL_LVL = 6
`endif
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FLUSH,
  input  logic                 ID_NQ,
  input  logic [31:0]          Instr_IN,
  input  logic [31:0]          Instr_PC_IN,
  input  logic [31:0]          Instr_PC_Plus4_IN,
  input  logic [4:0]           RS_IN,
  input  logic [4:0]           RT_IN,
  input  logic [4:0]           RD_IN,
  input  logic                 is_LDST_IN,
  input  logic [22:0]          Instr_Flags_IN,
  input  logic                 RNM_DQ,
  output logic [31:0]          Instr_OUT,
  output logic [31:0]          Instr_PC_OUT,
  output logic [31:0]          Instr_PC_Plus4_OUT,
  output logic [4:0]           RS_OUT,
  output logic [4:0]           RT_OUT,
  output logic [4:0]           RD_OUT,
  output logic                 is_LDST_OUT,
  output logic [22:0]          Instr_Flags_OUT,
  output logic                 RNMQ_empty,
  output logic                 RNMQ_full,
`ifdef RNMQ_AFULL_EN
  output logic                 RNMQ_afull,
`endif
  output logic [LOG_DEPTH:0]   RNMQ_count
);

  localparam int EW = 135;            // entry width
  localparam int PW = LOG_DEPTH;      // pointer width
  localparam int CW = LOG_DEPTH + 1;  // count width (must reach DEPTH)

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
`ifdef RNMQ_AFULL_EN
  logic          afull_q, afull_d;
`endif

  logic          push, pop, wr_en;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;

  assign wr_entry = {Instr_IN, Instr_PC_IN, Instr_PC_Plus4_IN,
                     RS_IN, RT_IN, RD_IN, is_LDST_IN, Instr_Flags_IN};

  // Flags come from the start-of-cycle registered state, so a full queue
  // refuses a push even when Rename pops in the same cycle, and an empty
  // queue ignores a pop even when decode pushes in the same cycle.
  always_comb begin
    push    = ID_NQ & ~full_q;
    pop     = RNM_DQ & ~empty_q;
    wr_en   = 1'b0;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (FLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      wr_en = push;
      if (push) tail_d = tail_q + PTR_ONE;   // wraps naturally: DEPTH is 2**PW
      if (pop)  head_d = head_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
`ifdef RNMQ_AFULL_EN
    afull_d = (count_d >= CW'(AFULL_LVL));
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
`ifdef RNMQ_AFULL_EN
      afull_q <= 1'b0;
`endif
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
`ifdef RNMQ_AFULL_EN
      afull_q <= afull_d;
`endif
    end
  end

  // Storage carries no reset; stale contents are never visible because the
  // outputs are masked while empty and pointers restart at 0.
  always_ff @(posedge CLK) begin
    if (!RESET && wr_en) mem[tail_q] <= wr_entry;
  end

  // Show-ahead head: combinational read of the oldest entry.
  assign head_entry = empty_q ? '0 : mem[head_q];

  assign {Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT,
          RS_OUT, RT_OUT, RD_OUT, is_LDST_OUT, Instr_Flags_OUT} = head_entry;

  assign RNMQ_empty = empty_q;
  assign RNMQ_full  = full_q;
  assign RNMQ_count = count_q;
`ifdef RNMQ_AFULL_EN
  assign RNMQ_afull = afull_q;
`endif

endmodule
